// File: rtl/serial_word_shifter.sv
// Parallel-to-serial front end: one-word holding buffer feeding a bit-serial
// shifter that drives the detector input stream x, gap-free between words.
module serial_word_shifter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_reg, hold_reg_nxt;
  logic             hold_full, hold_full_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             x_nxt, x_valid_nxt, frame_start_nxt;
  logic             accept, load;

  // Accept and load are mutually exclusive: accept needs an empty hold, load a full one.
  assign accept    = din_valid & ~hold_full;
  assign load      = hold_full & ((state == IDLE) | (cnt == LAST));
  assign din_ready = ~hold_full;
  assign busy      = (state == SHIFT) | hold_full;

  always_comb begin
    state_nxt       = state;
    hold_reg_nxt    = hold_reg;
    hold_full_nxt   = hold_full;
    shreg_nxt       = shreg;
    cnt_nxt         = cnt;
    x_nxt           = x;
    x_valid_nxt     = x_valid;
    frame_start_nxt = 1'b0;

    if (accept) begin
      hold_reg_nxt  = din;
      hold_full_nxt = 1'b1;
    end

    if (load) begin
      shreg_nxt       = hold_reg;
      hold_full_nxt   = 1'b0;
      cnt_nxt         = '0;
      state_nxt       = SHIFT;
      x_nxt           = MSB_FIRST ? hold_reg[WIDTH-1] : hold_reg[0];
      x_valid_nxt     = 1'b1;
      frame_start_nxt = 1'b1;
    end else if (state == SHIFT) begin
      if (cnt == LAST) begin
        state_nxt   = IDLE;
        x_nxt       = IDLE_BIT;
        x_valid_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt + CW'(1);
        // Rotate so the next bit in transmit order sits next to the current one.
        if (MSB_FIRST) begin
          x_nxt     = shreg[WIDTH-2];
          shreg_nxt = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
        end else begin
          x_nxt     = shreg[1];
          shreg_nxt = {shreg[0], shreg[WIDTH-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_reg    <= hold_reg_nxt;
      hold_full   <= hold_full_nxt;
      shreg       <= shreg_nxt;
      cnt         <= cnt_nxt;
      x           <= x_nxt;
      x_valid     <= x_valid_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: directed scenarios plus a randomized stream
// checked against a word-queue model of the serial output.
module tb_serial_word_shifter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, x, x_valid, frame_start, busy;
  logic [W-1:0] din_l = '0;
  logic         din_valid_l = 1'b0;
  logic         din_ready_l, x_l, x_valid_l, frame_start_l, busy_l;

  int errors = 0;
  int checks = 0;

  serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .x(x), .x_valid(x_valid), .frame_start(frame_start), .busy(busy)
  );

  serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .x(x_l), .x_valid(x_valid_l), .frame_start(frame_start_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    din_valid = 1'b0;
    din_valid_l = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({x, x_valid, frame_start, din_ready, busy} !== 5'b10010) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got x/xv/fs/rdy/busy=%b want 10010", i,
                 {x, x_valid, frame_start, din_ready, busy});
      end
    end
  endtask

  task automatic test_single(input logic [W-1:0] w);
    do_reset();
    din = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if ({din_ready, x_valid, busy} !== 3'b001) begin
      errors++;
      $display("FAIL single_accept got rdy/xv/busy=%b want 001", {din_ready, x_valid, busy});
    end
    for (int i = 0; i < int'(W); i++) begin
      tick();
      checks++;
      if ({x, x_valid, frame_start} !== {w[W-1-i], 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL single_bit w=%h i=%0d got x/xv/fs=%b want %b", w, i,
                 {x, x_valid, frame_start}, {w[W-1-i], 1'b1, (i == 0)});
      end
    end
    tick();
    checks++;
    if ({x, x_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL single_end w=%h got x/xv/busy=%b want 100", w, {x, x_valid, busy});
    end
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] s;
    s = {8'hA4, 8'h80};
    do_reset();
    din = 8'hA4;
    din_valid = 1'b1;
    tick();
    din = 8'h80;
    checks++;
    if (din_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_full got %b want 0", din_ready);
    end
    for (int k = 1; k <= 2 * int'(W); k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (din_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_after_load got %b want 1", din_ready);
        end
      end
      if (k == 2) begin
        din_valid = 1'b0;
        checks++;
        if (din_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second_accept got rdy=%b want 0", din_ready);
        end
      end
      checks++;
      if ({x, x_valid, frame_start} !== {s[2*W-k], 1'b1, (k == 1 || k == int'(W) + 1)}) begin
        errors++;
        $display("FAIL b2b_bit k=%0d got x/xv/fs=%b want %b", k, {x, x_valid, frame_start},
                 {s[2*W-k], 1'b1, (k == 1 || k == int'(W) + 1)});
      end
    end
    tick();
    checks++;
    if ({x, x_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_end got x/xv/busy=%b want 100", {x, x_valid, busy});
    end
  endtask

  // Model: the serial output is a queue of pending bits; a held word is
  // expanded into the queue once the previous word's bits have all been shown.
  task automatic test_stream(input int cycles, input int pct);
    bit           q[$];
    bit           m_full;
    logic [W-1:0] m_hold;
    logic [W-1:0] d;
    bit           acc, ex, ev, efs;
    do_reset();
    m_full = 1'b0;
    m_hold = '0;
    q.delete();
    for (int c = 0; c < cycles; c++) begin
      din_valid = ($urandom_range(99) < pct);
      din = W'($urandom);
      d = din;
      checks++;
      if (din_ready !== !m_full) begin
        errors++;
        $display("FAIL stream_ready c=%0d got %b want %b", c, din_ready, !m_full);
      end
      acc = din_valid && !m_full;
      tick();
      if (q.size() > 0) begin
        ex = q.pop_front();
        ev = 1'b1;
        efs = 1'b0;
      end else if (m_full) begin
        for (int i = 0; i < int'(W); i++) q.push_back(m_hold[W-1-i]);
        ex = q.pop_front();
        ev = 1'b1;
        efs = 1'b1;
        m_full = 1'b0;
      end else begin
        ex = 1'b1;
        ev = 1'b0;
        efs = 1'b0;
      end
      if (acc) begin
        m_full = 1'b1;
        m_hold = d;
      end
      checks++;
      if ({x, x_valid, frame_start, busy} !== {ex, ev, efs, ev | m_full}) begin
        errors++;
        $display("FAIL stream_out pct=%0d c=%0d got x/xv/fs/busy=%b want %b", pct, c,
                 {x, x_valid, frame_start, busy}, {ex, ev, efs, ev | m_full});
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_lsb_first;
    logic [W-1:0] w;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      w = (n == 0) ? 8'h01 : W'($urandom);
      din_l = w;
      din_valid_l = 1'b1;
      tick();
      din_valid_l = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
        tick();
        checks++;
        if ({x_l, x_valid_l, frame_start_l} !== {w[i], 1'b1, (i == 0)}) begin
          errors++;
          $display("FAIL lsb_bit w=%h i=%0d got x/xv/fs=%b want %b", w, i,
                   {x_l, x_valid_l, frame_start_l}, {w[i], 1'b1, (i == 0)});
        end
      end
      tick();
      checks++;
      if ({x_l, x_valid_l, busy_l} !== 3'b100) begin
        errors++;
        $display("FAIL lsb_end w=%h got x/xv/busy=%b want 100", w, {x_l, x_valid_l, busy_l});
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    din = 8'hA4;
    din_valid = 1'b1;
    tick();
    din = 8'h5A;
    tick();
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({x, x_valid, busy} !== 3'b011) begin
      errors++;
      $display("FAIL mid_before got x/xv/busy=%b want 011", {x, x_valid, busy});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({x, x_valid, busy, din_ready, frame_start} !== 5'b10010) begin
      errors++;
      $display("FAIL mid_async got x/xv/busy/rdy/fs=%b want 10010",
               {x, x_valid, busy, din_ready, frame_start});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({x, x_valid, busy, frame_start} !== 4'b1000) begin
        errors++;
        $display("FAIL mid_after cyc=%0d got x/xv/busy/fs=%b want 1000", i,
                 {x, x_valid, busy, frame_start});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA4);
    test_single(W'($urandom));
    test_back_to_back();
    test_stream(60, 100);
    test_stream(300, 45);
    test_lsb_first();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_shifter.md
Name: serial_word_shifter

Overview:
Parallel-to-serial front end that drives the single-bit serial stream `x` into the sequence detectors, one bit per clock. It accepts `WIDTH`-bit words over a valid/ready handshake into a one-word holding buffer. It then shifts each word out bit-serially, with no gap between back-to-back words. When no word is pending it drives a fixed idle level.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.
- IDLE_BIT, 1'b1: level driven on `x` while no word is being shifted.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to send.
- din_valid  input  1  `din` is valid this cycle.
- din_ready  output  1  holding buffer empty; a word is accepted at a posedge where din_valid && din_ready.
- x  output  1  registered serial bit; feeds the detector `x` input.
- x_valid  output  1  registered; 1 while `x` carries a data bit, 0 while `x` = IDLE_BIT.
- frame_start  output  1  registered; 1 for exactly the cycle `x` carries the first bit of a word.
- busy  output  1  1 when in SHIFT or the holding buffer is full.

Behaviour:
- Storage:
  - hold_reg[WIDTH-1:0] plus hold_full flag.
  - shreg[WIDTH-1:0] shift register.
  - cnt bit counter, $clog2(WIDTH) bits.
  - state: IDLE or SHIFT.
- Reset (asynchronous, immediate on rst rising):
  - state = IDLE, hold_full = 0, cnt = 0, shreg = 0.
  - x = IDLE_BIT, x_valid = 0, frame_start = 0.
  - din_ready = 1 (combinational ~hold_full).
  - Any word in flight or held is discarded, with no partial completion after reset release.
- Handshake:
  - din_ready = ~hold_full, with no combinational path from din_valid.
  - On accept: hold_reg <= din, hold_full <= 1.
  - While hold_full = 1, din is ignored regardless of din_valid; the producer must hold din/din_valid stable.
- Load event, which occurs at a posedge when hold_full = 1 and either state = IDLE or (state = SHIFT and cnt = WIDTH-1). On load:
  - shreg <= hold_reg, hold_full <= 0, cnt <= 0, state <= SHIFT.
  - x <= first bit (hold_reg[WIDTH-1] if MSB_FIRST else hold_reg[0]).
  - x_valid <= 1, frame_start <= 1.
- SHIFT, when cnt < WIDTH-1:
  - cnt <= cnt + 1.
  - x <= next bit in transmit order; x_valid stays 1; frame_start <= 0.
- SHIFT end, when cnt = WIDTH-1 and hold_full = 0:
  - state <= IDLE, x <= IDLE_BIT, x_valid <= 0, frame_start <= 0.
- Latency: word accepted at edge N produces its first bit on `x` from edge N+1. Each bit is held exactly one cycle.
- Throughput:
  - Hold empties at the load edge, so the next word can be accepted one edge later, well before the current word ends (WIDTH ≥ 2).
  - A continuous producer therefore yields a gap-free stream.
  - frame_start repeats every WIDTH cycles.
- No accept and load collide: hold can never be written and drained at the same edge, because din_ready is 0 while full.
- busy = (state == SHIFT) | hold_full.
- Idle output: x = IDLE_BIT whenever x_valid = 0. The default of 1 guarantees idle periods never complete a "100" pattern downstream.

Test Plan:
- Reset, then idle for 10 cycles → x = 1, x_valid = 0, frame_start = 0, din_ready = 1, busy = 0.
- WIDTH = 8, MSB_FIRST = 1, din = 8'hA4 accepted at edge N → from edge N+1, x = 1,0,1,0,0,1,0,0 on successive cycles. x_valid is 1 for exactly 8 cycles; frame_start is 1 only in the first of them; x returns to 1 at edge N+9.
- Back-to-back: 8'hA4 at edge N, then 8'h80 held valid → 8'h80 accepted at edge N+2 (din_ready 0 at N+1, 1 at N+2). x carries 16 contiguous bits 10100100_10000000 with no idle cycle; frame_start pulses at edges N+1 and N+9.
- Backpressure: with the hold buffer full, din_valid = 1 and din changing every cycle → din_ready = 0 and no value is captured until the buffer drains. The word present at the first din_ready = 1 edge is the one transmitted.
- MSB_FIRST = 0, din = 8'h01 → x = 1,0,0,0,0,0,0,0. Integration with the "100" Moore detector: the detector output y rises one cycle after the third bit.
- Reset asserted mid-word (after bit 3 of 8'hA4), with a second word held → x = 1, x_valid = 0, busy = 0 immediately. After release, no residual bits are emitted until a new word is accepted.
